// File: rtl/mems_dac_spi_tx_if.sv
// Bus between scan control / mems_rom and the DAC serializer.
// master: the serializer side; slave: the controller, ROM and DAC side.
interface mems_dac_spi_tx_if #(
    parameter int WORD_W = 24,
    parameter int ADDR_W = 16
) ();
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] rom_data;
    logic              rom_scan_is_done;
    logic [ADDR_W-1:0] addr;
    logic              sync_n;
    logic              sclk;
    logic              din;
    logic              busy;
    logic              scan_done;

    modport master (
        input  start, abort, rom_data, rom_scan_is_done,
        output addr, sync_n, sclk, din, busy, scan_done
    );

    modport slave (
        output start, abort, rom_data, rom_scan_is_done,
        input  addr, sync_n, sclk, din, busy, scan_done
    );
endinterface

// File: rtl/mems_dac_spi_tx.sv
// Walks mems_rom from addr 0 and shifts each word MSB-first onto the DAC SYNC_n/SCLK/DIN bus.
// MEMS_TX_LOOP_EN: on end-of-table restart from addr 0 instead of returning to IDLE.
module mems_dac_spi_tx #(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4,
    parameter int WORD_W  = 24,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    mems_dac_spi_tx_if.master dac
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int TW = $clog2(2 * WORD_W);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(2 * WORD_W - 1);

    logic [2:0]        state;
    logic              fetch_2nd;
    logic [DW-1:0]     div_cnt;
    logic [TW-1:0]     tog_cnt;
    logic [GW-1:0]     gap_cnt;
    // MSB goes straight to din at LOAD, so only the remaining bits are held
    logic [WORD_W-2:0] shift_reg;
    logic [ADDR_W-1:0] addr_r;
    logic              sync_n_r, sclk_r, din_r, busy_r, scan_done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_2nd   <= 1'b0;
            div_cnt     <= '0;
            tog_cnt     <= '0;
            gap_cnt     <= '0;
            shift_reg   <= '0;
            addr_r      <= '0;
            sync_n_r    <= 1'b1;
            sclk_r      <= 1'b1;
            din_r       <= 1'b0;
            busy_r      <= 1'b0;
            scan_done_r <= 1'b0;
        end else begin
            scan_done_r <= 1'b0;
            if (dac.abort) begin
                state     <= S_IDLE;
                fetch_2nd <= 1'b0;
                div_cnt   <= '0;
                tog_cnt   <= '0;
                gap_cnt   <= '0;
                addr_r    <= '0;
                sync_n_r  <= 1'b1;
                sclk_r    <= 1'b1;
                din_r     <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (dac.start) begin
                        state     <= S_FETCH;
                        fetch_2nd <= 1'b0;
                        addr_r    <= '0;
                        busy_r    <= 1'b1;
                    end
                    S_FETCH: begin
                        // first cycle lets the registered ROM catch up with addr
                        fetch_2nd <= ~fetch_2nd;
                        if (fetch_2nd) begin
                            if (dac.rom_scan_is_done) begin
                                scan_done_r <= 1'b1;
                                addr_r      <= '0;
`ifdef MEMS_TX_LOOP_EN
                                state       <= S_FETCH;
`else
                                state       <= S_IDLE;
                                busy_r      <= 1'b0;
`endif
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        shift_reg <= dac.rom_data[WORD_W-2:0];
                        din_r     <= dac.rom_data[WORD_W-1];
                        sync_n_r  <= 1'b0;
                        div_cnt   <= '0;
                        tog_cnt   <= '0;
                        state     <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            sclk_r  <= ~sclk_r;
                            tog_cnt <= tog_cnt + 1'b1;
                            if (tog_cnt == TOG_LAST) begin
                                sclk_r   <= 1'b1;
                                sync_n_r <= 1'b1;
                                tog_cnt  <= '0;
                                gap_cnt  <= '0;
                                state    <= S_GAP;
                            end else if (!sclk_r) begin
                                // rising edge: present next bit well clear of the next fall
                                din_r     <= shift_reg[WORD_W-2];
                                shift_reg <= {shift_reg[WORD_W-3:0], 1'b0};
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt   <= '0;
                            addr_r    <= addr_r + 1'b1;
                            fetch_2nd <= 1'b0;
                            state     <= S_FETCH;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dac.addr      = addr_r;
    assign dac.sync_n    = sync_n_r;
    assign dac.sclk      = sclk_r;
    assign dac.din       = din_r;
    assign dac.busy      = busy_r;
    assign dac.scan_done = scan_done_r;
endmodule
